// File: rtl/loader_pkg.sv
// Shared constants for the UART program loader: state encodings, sync byte,
// and the baud divisor helper.
package loader_pkg;

  // Loader FSM encodings
  localparam logic [1:0] L_IDLE  = 2'd0;
  localparam logic [1:0] L_LEN   = 2'd1;
  localparam logic [1:0] L_DATA  = 2'd2;
  localparam logic [1:0] L_CHK   = 2'd3;

  // UART receive FSM encodings
  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_START = 2'd1;
  localparam logic [1:0] R_DATA  = 2'd2;
  localparam logic [1:0] R_STOP  = 2'd3;

  // Byte that opens a load frame
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Clocks per UART bit, truncated
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned baud);
    calc_div = clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// UART byte receiver: two-flop synchronizer, start-bit glitch rejection,
// mid-bit sampling, LSB-first shift, stop-bit check.
// Emits one-cycle byte_valid with rx_byte, or one-cycle frame_err.
module uart_rx_byte
  import loader_pkg::*;
#(
  parameter int unsigned DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int unsigned      CNT_W     = $clog2(DIV + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(DIV - 1);

  logic             rx_meta_q, rx_meta_d;
  logic             rx_sync_q, rx_sync_d;
  logic             rx_prev_q, rx_prev_d;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_err_q, frame_err_d;

  // Next-state: synchronizer chain, baud counting and bit sampling
  always_comb begin
    rx_meta_d    = rx;
    rx_sync_d    = rx_meta_q;
    rx_prev_d    = rx_sync_q;
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shreg_d      = shreg_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (state_q)
      R_IDLE: begin
        cnt_d = CNT_ZERO;
        if (rx_prev_q && !rx_sync_q) begin
          state_d = R_START;
        end else begin
          state_d = R_IDLE;
        end
      end
      R_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = CNT_ZERO;
          bit_d = 3'd0;
          // A line back high at mid start bit was only a glitch
          if (rx_sync_q) begin
            state_d = R_IDLE;
          end else begin
            state_d = R_DATA;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      R_DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = CNT_ZERO;
          shreg_d = {rx_sync_q, shreg_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = R_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      R_STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = CNT_ZERO;
          state_d = R_IDLE;
          if (rx_sync_q) begin
            byte_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = R_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // State registers; synchronizer resets to the idle-high line level
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      state_q      <= R_IDLE;
      cnt_q        <= CNT_ZERO;
      bit_q        <= 3'd0;
      shreg_q      <= 8'h00;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_meta_q    <= rx_meta_d;
      rx_sync_q    <= rx_sync_d;
      rx_prev_q    <= rx_prev_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shreg_q      <= shreg_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign rx_byte    = shreg_q;
  assign byte_valid = byte_valid_q;
  assign frame_err  = frame_err_q;

endmodule

// File: rtl/uart_prog_loader.sv
// UART program loader: receives A5 / length / little-endian words and writes
// them into instruction memory while holding the CPU core in reset.
// Optional trailing XOR checksum byte enabled by defining LOADER_CHECKSUM_EN.
module uart_prog_loader
  import loader_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 100000000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam int unsigned      DIV      = calc_div(CLK_HZ, BAUD);
  localparam int unsigned      DEPTH    = 2 ** ADDR_W;
  // Wide enough for both a raw length byte and the full depth
  localparam int unsigned      LEN_W    = (ADDR_W + 1 > 9) ? ADDR_W + 1 : 9;
  localparam int unsigned      TMO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [LEN_W-1:0] DEPTH_L  = LEN_W'(DEPTH);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic [7:0]        rx_byte_s;
  logic              byte_valid_s;
  logic              frame_err_s;
  logic [LEN_W-1:0]  len_ext_s;
  logic              abort_s;

  logic [1:0]        state_q, state_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [LEN_W-1:0]  word_cnt_q, word_cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [23:0]       asm_q, asm_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        xsum_q, xsum_d;
`endif

  uart_rx_byte #(
    .DIV (DIV)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .rx_byte    (rx_byte_s),
    .byte_valid (byte_valid_s),
    .frame_err  (frame_err_s)
  );

  // A length byte of zero stands for the full memory depth
  assign len_ext_s = (rx_byte_s == 8'h00) ? DEPTH_L : LEN_W'(rx_byte_s);

  // Line faults only matter once a load is in progress
  assign abort_s = (state_q != L_IDLE) &&
                   (frame_err_s || (!byte_valid_s && (tmo_q == TMO_LAST)));

  // Loader next-state: framing, word assembly, memory writes, aborts
  always_comb begin
    state_d    = state_q;
    cpu_hold_d = cpu_hold_q;
    done_d     = done_q;
    err_d      = err_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    word_cnt_d = word_cnt_q;
    len_d      = len_q;
    byte_idx_d = byte_idx_q;
    asm_d      = asm_q;
`ifdef LOADER_CHECKSUM_EN
    xsum_d     = xsum_q;
`endif

    // Idle gap counter runs only inside a load and restarts on every byte
    if ((state_q == L_IDLE) || byte_valid_s) begin
      tmo_d = {TMO_W{1'b0}};
    end else begin
      tmo_d = tmo_q + TMO_W'(1);
    end

    case (state_q)
      L_IDLE: begin
        if (byte_valid_s && (rx_byte_s == SYNC_BYTE)) begin
          state_d    = L_LEN;
          cpu_hold_d = 1'b1;
          done_d     = 1'b0;
          err_d      = 1'b0;
          word_cnt_d = {LEN_W{1'b0}};
          byte_idx_d = 2'd0;
`ifdef LOADER_CHECKSUM_EN
          xsum_d     = 8'h00;
`endif
        end else begin
          state_d = L_IDLE;
        end
      end
      L_LEN: begin
        if (byte_valid_s) begin
          if (len_ext_s > DEPTH_L) begin
            err_d      = 1'b1;
            cpu_hold_d = 1'b0;
            state_d    = L_IDLE;
          end else begin
            len_d   = len_ext_s;
            state_d = L_DATA;
          end
        end else begin
          state_d = L_LEN;
        end
      end
      L_DATA: begin
        // Finish the cycle after the last write so hold drops one cycle later
        if (we_q && (word_cnt_q == len_q)) begin
`ifdef LOADER_CHECKSUM_EN
          state_d    = L_CHK;
`else
          state_d    = L_IDLE;
          done_d     = 1'b1;
          cpu_hold_d = 1'b0;
`endif
        end else if (byte_valid_s) begin
`ifdef LOADER_CHECKSUM_EN
          xsum_d = xsum_q ^ rx_byte_s;
`endif
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            we_d       = 1'b1;
            addr_d     = word_cnt_q[ADDR_W-1:0];
            wdata_d    = {rx_byte_s, asm_q};
            word_cnt_d = word_cnt_q + LEN_W'(1);
          end else begin
            asm_d = {rx_byte_s, asm_q[23:8]};
          end
        end else begin
          state_d = L_DATA;
        end
      end
      L_CHK: begin
`ifdef LOADER_CHECKSUM_EN
        if (byte_valid_s) begin
          if (rx_byte_s == xsum_q) begin
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          cpu_hold_d = 1'b0;
          state_d    = L_IDLE;
        end else begin
          state_d = L_CHK;
        end
`else
        state_d = L_IDLE;
`endif
      end
      default: begin
        state_d    = L_IDLE;
        cpu_hold_d = 1'b0;
      end
    endcase

    if (abort_s) begin
      state_d    = L_IDLE;
      err_d      = 1'b1;
      cpu_hold_d = 1'b0;
    end else begin
      err_d = err_d;
    end
  end

  // Loader registers, all outputs driven straight from flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= L_IDLE;
      cpu_hold_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= {ADDR_W{1'b0}};
      wdata_q    <= 32'h0000_0000;
      word_cnt_q <= {LEN_W{1'b0}};
      len_q      <= {LEN_W{1'b0}};
      byte_idx_q <= 2'd0;
      asm_q      <= 24'h00_0000;
      tmo_q      <= {TMO_W{1'b0}};
`ifdef LOADER_CHECKSUM_EN
      xsum_q     <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      word_cnt_q <= word_cnt_d;
      len_q      <= len_d;
      byte_idx_q <= byte_idx_d;
      asm_q      <= asm_d;
      tmo_q      <= tmo_d;
`ifdef LOADER_CHECKSUM_EN
      xsum_q     <= xsum_d;
`endif
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_hold   = cpu_hold_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader at DIV=16, TIMEOUT_CYC=2000.
// Covers LOADER_CHECKSUM_EN builds as well by appending checksum bytes.
module tb_uart_prog_loader;

  localparam int unsigned CLK_HZ      = 160;
  localparam int unsigned BAUD        = 10;
  localparam int unsigned ADDR_W      = 6;
  localparam int unsigned TIMEOUT_CYC = 2000;
  localparam int          BIT_CYC     = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              rx;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_we_cyc   = -1;
  int hold_fall_cyc = -1;
  logic hold_prev   = 1'b0;

  logic [ADDR_W-1:0] wa_q[$];
  logic [31:0]       wd_q[$];

  uart_prog_loader #(
    .CLK_HZ      (CLK_HZ),
    .BAUD        (BAUD),
    .ADDR_W      (ADDR_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  // record memory writes and cpu_hold falling edges away from the clock edge
  always @(negedge clk) begin
    if (imem_we) begin
      wa_q.push_back(imem_addr);
      wd_q.push_back(imem_wdata);
      last_we_cyc = cyc;
    end
    if (hold_prev && !cpu_hold) hold_fall_cyc = cyc;
    hold_prev = cpu_hold;
  end

  // hard time limit
  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (BIT_CYC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT_CYC) @(negedge clk);
    end
    rx = stop_bit;
    repeat (BIT_CYC) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    send_byte(b, 1'b1);
  endtask

  // trailing checksum byte, only present when the option is built in
  task automatic send_chk(input logic [7:0] x);
`ifdef LOADER_CHECKSUM_EN
    send(x);
`else
    if (x == 8'h00) idle(1); else idle(1);
`endif
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
  endtask

  initial begin
    logic [7:0]  xs;
    logic [7:0]  b0, b1, b2, b3;
    rst = 1'b1;
    rx  = 1'b1;
    idle(5);

    // reset state
    chk("rst_we",    {31'd0, imem_we},   32'd0);
    chk("rst_addr",  {26'd0, imem_addr}, 32'd0);
    chk("rst_wdata", imem_wdata,         32'd0);
    chk("rst_hold",  {31'd0, cpu_hold},  32'd0);
    chk("rst_done",  {31'd0, done},      32'd0);
    chk("rst_err",   {31'd0, err},       32'd0);
    rst = 1'b0;
    idle(5);

    // two-word load
    send(8'hA5);
    chk("t1_hold_after_sync", {31'd0, cpu_hold}, 32'd1);
    send(8'h02);
    send(8'h13); send(8'h00); send(8'h10); send(8'h00);
    chk("t1_hold_mid", {31'd0, cpu_hold}, 32'd1);
    send(8'hB7); send(8'h02); send(8'h40); send(8'h00);
    send_chk(8'hF6);
    idle(30);
    chk("t1_nwr",   wa_q.size(),          32'd2);
    chk("t1_a0",    {26'd0, wa_q[0]},     32'd0);
    chk("t1_d0",    wd_q[0],              32'h0010_0013);
    chk("t1_a1",    {26'd0, wa_q[1]},     32'd1);
    chk("t1_d1",    wd_q[1],              32'h0040_02B7);
    chk("t1_done",  {31'd0, done},        32'd1);
    chk("t1_err",   {31'd0, err},         32'd0);
    chk("t1_hold",  {31'd0, cpu_hold},    32'd0);
`ifndef LOADER_CHECKSUM_EN
    chk("t1_hold_fall", hold_fall_cyc, last_we_cyc + 1);
`endif
    clear_log();

    // framing error on the third data byte
    send(8'hA5); send(8'h01);
    send(8'h13); send(8'h00);
    send_byte(8'h10, 1'b0);
    idle(40);
    chk("fe_err",  {31'd0, err},      32'd1);
    chk("fe_hold", {31'd0, cpu_hold}, 32'd0);
    chk("fe_done", {31'd0, done},     32'd0);
    chk("fe_nwr",  wa_q.size(),       32'd0);

    // garbage ignored in IDLE, then a one-word load
    send(8'h00); send(8'hFF); send(8'h3C);
    idle(5);
    chk("gb_hold", {31'd0, cpu_hold}, 32'd0);
    chk("gb_err_sticky", {31'd0, err}, 32'd1);
    send(8'hA5); send(8'h01);
    send(8'h13); send(8'h00); send(8'h10); send(8'h00);
    send_chk(8'h03);
    idle(30);
    chk("gb_nwr",  wa_q.size(),      32'd1);
    chk("gb_a0",   {26'd0, wa_q[0]}, 32'd0);
    chk("gb_d0",   wd_q[0],          32'h0010_0013);
    chk("gb_done", {31'd0, done},    32'd1);
    chk("gb_err",  {31'd0, err},     32'd0);
    clear_log();

    // length one past the depth
    send(8'hA5); send(8'h41);
    idle(30);
    chk("len41_err",  {31'd0, err},      32'd1);
    chk("len41_hold", {31'd0, cpu_hold}, 32'd0);
    chk("len41_done", {31'd0, done},     32'd0);
    chk("len41_nwr",  wa_q.size(),       32'd0);

    // length zero means the full 64 words
    send(8'hA5); send(8'h00);
    xs = 8'h00;
    for (int i = 0; i < 64; i++) begin
      b0 = 8'(i); b1 = 8'(i) ^ 8'h5A; b2 = 8'hC3; b3 = 8'(i + 3);
      send(b0); send(b1); send(b2); send(b3);
      xs = xs ^ b0 ^ b1 ^ b2 ^ b3;
    end
    send_chk(xs);
    idle(30);
    chk("full_nwr",  wa_q.size(),   32'd64);
    for (int i = 0; i < 64; i++) begin
      b0 = 8'(i); b1 = 8'(i) ^ 8'h5A; b2 = 8'hC3; b3 = 8'(i + 3);
      chk($sformatf("full_a%0d", i), {26'd0, wa_q[i]}, 32'(i));
      chk($sformatf("full_d%0d", i), wd_q[i], {b3, b2, b1, b0});
    end
    chk("full_done", {31'd0, done},     32'd1);
    chk("full_err",  {31'd0, err},      32'd0);
    chk("full_hold", {31'd0, cpu_hold}, 32'd0);
    clear_log();

    // timeout after two data bytes
    send(8'hA5); send(8'h01);
    send(8'h13); send(8'h00);
    idle(1000);
    chk("tmo_early_err",  {31'd0, err},      32'd0);
    chk("tmo_early_hold", {31'd0, cpu_hold}, 32'd1);
    idle(1100);
    chk("tmo_err",  {31'd0, err},      32'd1);
    chk("tmo_hold", {31'd0, cpu_hold}, 32'd0);
    chk("tmo_nwr",  wa_q.size(),       32'd0);

`ifdef LOADER_CHECKSUM_EN
    // checksum match and mismatch
    send(8'hA5); send(8'h01);
    send(8'h13); send(8'h00); send(8'h10); send(8'h00);
    send(8'h03);
    idle(30);
    chk("ck_ok_done", {31'd0, done}, 32'd1);
    chk("ck_ok_err",  {31'd0, err},  32'd0);
    clear_log();
    send(8'hA5); send(8'h01);
    send(8'h13); send(8'h00); send(8'h10); send(8'h00);
    send(8'h04);
    idle(30);
    chk("ck_bad_err",  {31'd0, err},      32'd1);
    chk("ck_bad_done", {31'd0, done},     32'd0);
    chk("ck_bad_hold", {31'd0, cpu_hold}, 32'd0);
    chk("ck_bad_nwr",  wa_q.size(),       32'd1);
    chk("ck_bad_a0",   {26'd0, wa_q[0]},  32'd0);
    chk("ck_bad_d0",   wd_q[0],           32'h0010_0013);
    clear_log();
    // leave a nonzero address behind for the reset check
    send(8'hA5); send(8'h02);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    send(8'h05); send(8'h06); send(8'h07); send(8'h08);
    send(8'h08);
    idle(30);
    chk("ck_two_done", {31'd0, done}, 32'd1);
`endif

    // reset in the middle of a byte
    send(8'hA5); send(8'h01);
    rx = 1'b0;
    idle(40);
    chk("mid_hold_before", {31'd0, cpu_hold}, 32'd1);
    chk("mid_addr_before", {26'd0, imem_addr} == 32'd0 ? 32'd1 : 32'd0, 32'd0);
    rst = 1'b1;
    idle(1);
    chk("mid_we",    {31'd0, imem_we},   32'd0);
    chk("mid_addr",  {26'd0, imem_addr}, 32'd0);
    chk("mid_wdata", imem_wdata,         32'd0);
    chk("mid_hold",  {31'd0, cpu_hold},  32'd0);
    chk("mid_done",  {31'd0, done},      32'd0);
    chk("mid_err",   {31'd0, err},       32'd0);
    rx  = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(20);
    chk("post_hold", {31'd0, cpu_hold}, 32'd0);
    chk("post_err",  {31'd0, err},      32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
